// File: rtl/gemm_loader.sv
// gemm_loader: streams m1 then m2 into gemm_core, pulses start, waits for done
// and returns sum_out (or a timeout result) on a valid/ready port.
module gemm_loader #(
  parameter int DATA_W         = 21,
  parameter int N_ELEM         = 256,
  parameter int GAP_CYCLES     = 3,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic [7:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              start,
  input  logic              done,
  input  logic [31:0]       sum_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic              timeout_err,
  output logic              busy
);

  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]    LAST     = 8'(N_ELEM - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD_M1,
    S_LOAD_M2,
    S_GAP,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_RESULT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]        r_cnt;
  logic [GW-1:0]     r_gap;
  logic [TW-1:0]     r_tmo;
  logic              r_s_ready;
  logic              r_wr_en;
  logic [1:0]        r_wr_sel;
  logic [7:0]        r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_start;
  logic              r_res_valid;
  logic [31:0]       r_res_data;
  logic              r_tmo_err;
  logic              r_busy;

  logic              w_acc;
  logic              w_wait;
  logic              w_tmo_hit;
  logic              w_load_nxt;
  logic [7:0]        w_cnt_nxt;
  logic [GW-1:0]     w_gap_nxt;
  logic [TW-1:0]     w_tmo_nxt;
  logic [31:0]       w_res_data_nxt;
  logic              w_tmo_err_nxt;

  // s_ready is only ever high while in a LOAD state, so it alone gates accepts
  assign w_acc     = s_valid & r_s_ready;
  assign w_wait    = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
  assign w_tmo_hit = w_wait && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD_M1;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_LOAD_M1:
        if (w_acc && r_cnt == LAST) w_state_nxt = S_LOAD_M2;
      S_LOAD_M2:
        if (w_acc && r_cnt == LAST) w_state_nxt = S_GAP;
      S_GAP:
        if (r_gap == GAP_LAST) w_state_nxt = S_START;
      S_START:
        w_state_nxt = S_WAIT_LO;
      S_WAIT_LO:
        if (w_tmo_hit)  w_state_nxt = S_RESULT;
        else if (!done) w_state_nxt = S_WAIT_HI;
      S_WAIT_HI:
        if (done || w_tmo_hit) w_state_nxt = S_RESULT;
      S_RESULT:
        if (res_ready) w_state_nxt = S_LOAD_M1;
      default:
        w_state_nxt = S_LOAD_M1;
    endcase
  end

  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_gap_nxt      = '0;
    w_tmo_nxt      = r_tmo;
    w_res_data_nxt = r_res_data;
    w_tmo_err_nxt  = r_tmo_err;
    if (w_acc) w_cnt_nxt = r_cnt + 8'd1;
    unique case (r_state)
      S_GAP:     w_gap_nxt = r_gap + GW'(1);
      S_START:   w_tmo_nxt = '0;
      S_WAIT_LO: w_tmo_nxt = r_tmo + TW'(1);
      S_WAIT_HI: w_tmo_nxt = r_tmo + TW'(1);
      S_RESULT:
        if (res_ready) begin
          w_cnt_nxt     = '0;
          w_tmo_err_nxt = 1'b0;
        end
      default: ;
    endcase
    // a real done wins over a timeout landing on the same cycle
    if (r_state == S_WAIT_HI && done) begin
      w_res_data_nxt = sum_out;
    end else if (w_tmo_hit) begin
      w_res_data_nxt = '0;
      w_tmo_err_nxt  = 1'b1;
    end
  end

  assign w_load_nxt = (w_state_nxt == S_LOAD_M1) ||
                      (w_state_nxt == S_LOAD_M2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_gap       <= '0;
      r_tmo       <= '0;
      r_s_ready   <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_sel    <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_start     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_tmo_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_gap       <= w_gap_nxt;
      r_tmo       <= w_tmo_nxt;
      r_s_ready   <= w_load_nxt;
      r_wr_en     <= w_acc;
      if (w_acc) begin
        r_wr_sel  <= {1'b0, r_state == S_LOAD_M2};
        r_wr_addr <= r_cnt;
        r_wr_data <= s_data;
      end
      r_start     <= (w_state_nxt == S_START);
      r_res_valid <= (w_state_nxt == S_RESULT);
      r_res_data  <= w_res_data_nxt;
      r_tmo_err   <= w_tmo_err_nxt;
      r_busy      <= !((w_state_nxt == S_LOAD_M1) && (w_cnt_nxt == 8'd0));
    end
  end

  assign s_ready     = r_s_ready;
  assign wr_en       = r_wr_en;
  assign wr_sel      = r_wr_sel;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign start       = r_start;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign timeout_err = r_tmo_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_gemm_loader.sv
// tb_gemm_loader: drives matrix jobs through gemm_loader into a behavioural
// gemm_core stub and checks results, write order and handshake timing.
module tb_gemm_loader;

  localparam int DW  = 21;
  localparam int GAP = 3;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [7:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          done;
  logic [31:0]   sum_out;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [31:0]   res_data;
  logic          timeout_err;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gemm_loader #(
    .DATA_W(DW), .N_ELEM(256), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .done(done), .sum_out(sum_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .timeout_err(timeout_err), .busy(busy)
  );

  // gemm_core stub: done drops a little after start, rises later with sum(m1*m2)
  logic signed [DW-1:0] cm1 [256];
  logic signed [DW-1:0] cm2 [256];
  bit stuck = 1'b0;
  bit run;
  int dropc, finc;

  function automatic logic [31:0] core_sum();
    longint s = 0;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 16; k++)
          s += longint'(cm1[8'(i*16+k)]) * longint'(cm2[8'(k*16+j)]);
    return 32'(s);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0; sum_out <= '0; run <= 1'b0; dropc <= 0; finc <= 0;
    end else begin
      if (wr_en && wr_sel == 2'd0) cm1[wr_addr] <= wr_data;
      if (wr_en && wr_sel == 2'd1) cm2[wr_addr] <= wr_data;
      if (start) begin
        run <= 1'b1;
        dropc <= int'($urandom_range(1, 4));
        finc <= int'($urandom_range(6, 25));
      end else if (run) begin
        if (dropc > 0) dropc <= dropc - 1;
        if (dropc == 1) done <= 1'b0;
        if (finc > 0) finc <= finc - 1;
        if (finc == 1) begin
          run <= 1'b0;
          if (!stuck) begin
            done <= 1'b1;
            sum_out <= core_sum();
          end
        end
      end
    end
  end

  // reference job content and observed traffic
  int A [256];
  int B [256];
  int            acc_cyc [$];
  int            wq_cyc  [$];
  logic [1:0]    wq_sel  [$];
  logic [7:0]    wq_addr [$];
  logic [DW-1:0] wq_data [$];
  int            st_cyc  [$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_cyc.push_back(cyc);
      wq_sel.push_back(wr_sel);
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (start === 1'b1) st_cyc.push_back(cyc);
  end

  function automatic int elem(input int i);
    return (i < 256) ? A[8'(i)] : B[8'(i - 256)];
  endfunction

  function automatic logic [31:0] ref_sum();
    longint s = 0;
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++)
        if (i % 16 == j / 16) s += longint'(A[8'(i)]) * longint'(B[8'(j)]);
    return 32'(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    acc_cyc.delete(); wq_cyc.delete(); wq_sel.delete();
    wq_addr.delete(); wq_data.delete(); st_cyc.delete();
  endtask

  task automatic drive(input int pct, input int n);
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 20000) begin
      @(negedge clk);
      guard++;
      s_valid = ($urandom_range(0, 99) < pct);
      s_data = DW'(elem(idx));
      if (s_valid && s_ready) begin
        acc_cyc.push_back(cyc + 1);
        idx++;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("drive_accepts", 64'(idx), 64'(n));
  endtask

  task automatic job(input string nm, input int pct, input int bp,
                     input logic [31:0] exp_sum, input logic exp_tmo);
    int guard = 0;
    int bad;
    logic [31:0] held;
    clear_q();
    drive(pct, 512);
    while (res_valid !== 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_res_valid"}, 64'(res_valid), 64'(1));
    chk({nm, "_res_data"}, 64'(res_data), 64'(exp_sum));
    chk({nm, "_timeout_err"}, 64'(timeout_err), 64'(exp_tmo));
    chk({nm, "_busy_res"}, 64'(busy), 64'(1));
    chk({nm, "_s_ready_res"}, 64'(s_ready), 64'(0));
    chk({nm, "_wr_count"}, 64'(wq_sel.size()), 64'(512));
    bad = 0;
    for (int i = 0; i < wq_sel.size() && i < 512; i++)
      if (wq_sel[i] !== 2'(i / 256) || wq_addr[i] !== 8'(i % 256) ||
          wq_data[i] !== DW'(elem(i))) bad++;
    chk({nm, "_wr_seq_errs"}, 64'(bad), 64'(0));
    bad = (wq_cyc.size() != acc_cyc.size()) ? 1 : 0;
    for (int i = 0; i < wq_cyc.size() && i < acc_cyc.size(); i++)
      if (wq_cyc[i] != acc_cyc[i]) bad++;
    chk({nm, "_wr_vs_accept"}, 64'(bad), 64'(0));
    chk({nm, "_start_cycles"}, 64'(st_cyc.size()), 64'(1));
    if (st_cyc.size() > 0 && wq_cyc.size() > 0)
      chk({nm, "_gap_idle"}, 64'(st_cyc[0] - wq_cyc[$] - 1), 64'(GAP));
    if (bp > 0) begin
      held = res_data;
      bad = 0;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || res_data !== held || s_ready !== 1'b0) bad++;
      end
      chk({nm, "_backpressure"}, 64'(bad), 64'(0));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({nm, "_s_ready_after"}, 64'(s_ready), 64'(1));
    chk({nm, "_res_valid_after"}, 64'(res_valid), 64'(0));
    chk({nm, "_tmo_err_after"}, 64'(timeout_err), 64'(0));
    chk({nm, "_busy_after"}, 64'(busy), 64'(0));
  endtask

  task automatic fill(input int kind);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        case (kind)
          0: begin A[8'(r*16+c)] = 1; B[8'(r*16+c)] = 1; end
          1: begin A[8'(r*16+c)] = (r == c) ? 1 : 0; B[8'(r*16+c)] = c + 1; end
          2: begin A[8'(r*16+c)] = r + 1; B[8'(r*16+c)] = c + 1; end
          default: begin
            A[8'(r*16+c)] = int'($urandom_range(0, 2097151)) - 1048576;
            B[8'(r*16+c)] = int'($urandom_range(0, 2097151)) - 1048576;
          end
        endcase
      end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({s_ready, wr_en, wr_sel, start, res_valid,
                         timeout_err, busy}), 64'(0));
    chk("rst_data", 64'({wr_addr, wr_data, res_data}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", 64'(s_ready), 64'(1));
    chk("idle_busy", 64'(busy), 64'(0));

    fill(0); job("ones", 100, 0, 32'd4096, 1'b0);
    fill(1); job("ident", 100, 0, 32'd2176, 1'b0);
    fill(2); job("rowcol", 100, 0, 32'd295936, 1'b0);
    fill(0); job("gaps", 50, 0, 32'd4096, 1'b0);
    fill(3); job("rand_bp", 70, 20, ref_sum(), 1'b0);

    stuck = 1'b1;
    fill(0); job("timeout", 100, 0, 32'd0, 1'b1);
    stuck = 1'b0;

    clear_q();
    fill(0);
    drive(100, 100);
    #1;
    chk("part_writes", 64'(wq_sel.size()), 64'(100));
    chk("part_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({s_ready, wr_en, wr_sel, start, res_valid,
                            timeout_err, busy}), 64'(0));
    chk("midrst_data", 64'({wr_addr, wr_data, res_data}), 64'(0));
    repeat (2) @(negedge clk);
    chk("midrst_no_start", 64'(st_cyc.size()), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    fill(0); job("ones_rst", 100, 0, 32'd4096, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gemm_loader.md
# gemm_loader

Master-side driver for the `gemm_core` load/compute interface. It accepts a stream of matrix elements on a valid/ready port and writes them into `gemm_core`: 256 words of m1, then 256 words of m2. It then pulses `start`, waits for completion and returns `sum_out` on a valid/ready result port. It sits between the host/DMA stream and `gemm_core` and replaces bench-style register poking in the integrated design.

## Interface
- `DATA_W`, 21: element width, signed, passed unchanged to `wr_data`
- `N_ELEM`, 256: elements per matrix (16x16); `wr_addr` is 8 bits
- `GAP_CYCLES`, 3: idle cycles between the last write and `start`
- `TIMEOUT_CYCLES`, 10_000_000: maximum cycles spent waiting for `done`

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `s_valid`  in  1  element valid
- `s_ready`  out  1  element accepted when `s_valid` and `s_ready` are both high
- `s_data`  in  DATA_W  signed element, row-major (r*16+c), m1 first then m2
- `wr_en`  out  1  write strobe to `gemm_core`
- `wr_sel`  out  2  0 = m1, 1 = m2; values 2 and 3 are never driven
- `wr_addr`  out  8  element address
- `wr_data`  out  DATA_W  element data
- `start`  out  1  one-cycle compute request
- `done`  in  1  `gemm_core` completion level
- `sum_out`  in  32  `gemm_core` result
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when `res_valid` and `res_ready` are both high
- `res_data`  out  32  captured `sum_out`, or 0 on timeout
- `timeout_err`  out  1  qualifies `res_valid`: result came from a timeout
- `busy`  out  1  high in every state except LOAD_M1 with `cnt` = 0

## Operation
- States: LOAD_M1, LOAD_M2, GAP, START, WAIT_LO, WAIT_HI, RESULT.
- Reset: state LOAD_M1, element counter `cnt` = 0, gap/timeout counters 0. All outputs are 0, including `s_ready`, `wr_*`, `start`, `res_*` and `timeout_err`.
- **LOAD_M1 / LOAD_M2**
  - `s_ready` = 1.
  - Each accepted element registers `wr_en`=1, `wr_sel` (0 in LOAD_M1, 1 in LOAD_M2), `wr_addr`=`cnt` and `wr_data`=`s_data`. Then `cnt`++.
  - `wr_en` is 0 on any cycle without an accept.
  - When `cnt` wraps from 255 to 0: LOAD_M1 goes to LOAD_M2, and LOAD_M2 goes to GAP.
- **GAP**
  - `s_ready` = 0.
  - Counts GAP_CYCLES idle cycles after the final write strobe, then goes to START.
- **START**
  - `start` = 1 for exactly one cycle, then go to WAIT_LO.
  - Clear the timeout counter.
- **WAIT_LO**
  - Stay while `done` = 1, then go to WAIT_HI.
  - This covers `done` still being held high from the previous job.
- **WAIT_HI**
  - On `done` = 1: capture `sum_out` into `res_data`, set `res_valid` = 1, go to RESULT.
- **Timeout**
  - The timeout counter advances in WAIT_LO and WAIT_HI.
  - When it reaches TIMEOUT_CYCLES: `res_data` = 0, `timeout_err` = 1, `res_valid` = 1, go to RESULT.
- **RESULT**
  - `res_valid` and `res_data` are held stable until `res_ready`.
  - On handshake: clear `res_valid` and `timeout_err`, set `cnt` = 0, go to LOAD_M1.
- Elements offered outside the LOAD states are not accepted; upstream must hold them.
- Asserting `rst_n` low mid-job aborts immediately and returns to reset values. No partial `start` pulse is issued.

## Timing
- Element accepted in cycle k: its write strobe appears in cycle k+1. Back-to-back accepts give one write per cycle, with no bubbles.
- Minimum load time is 512 cycles.
- Last m2 element accepted in cycle k:
  - `wr_en` is high in cycle k+1.
  - Cycles k+2 through k+1+GAP_CYCLES are idle.
  - `start` is high in cycle k+2+GAP_CYCLES.
- `done` is sampled no earlier than the cycle after `start`.
- Done observed high in cycle d (in WAIT_HI): `res_valid` goes high in cycle d+1.
- Result handshake in cycle h: `s_ready` goes high in cycle h+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **All ones** (m1 = m2 = 1, `s_valid` held high, `res_ready` = 1, real `gemm_core`)
  - Required: `res_data` = 4096 and `timeout_err` = 0.
  - Required: exactly 512 `wr_en` cycles, with `wr_addr` sequence 0..255 on `wr_sel` 0 then 0..255 on `wr_sel` 1.
- **Identity x column-increment**
  - Required: 2176.
  - Then row-increment x column-increment, back to back: required 295936.
  - This checks the done-high-from-previous-job path.
- **Random `s_valid` gaps** (about 50%) on the ones x ones job
  - Required: 4096.
  - Required: a `wr_en` pulse only on cycles following an accept, and addresses strictly sequential.
- **Gap and start timing**
  - Measure the cycle of the last write and the `start` cycle: required exactly GAP_CYCLES idle cycles between them.
  - Required: `start` is high for exactly one cycle.
- **Result back-pressure**: hold `res_ready` = 0 for 20 cycles.
  - Required: `res_valid` and `res_data` stable throughout, `s_ready` = 0 throughout.
  - Required: `s_ready` = 1 in the cycle after `res_ready` is raised.
- **Timeout and reset**
  - Stub core with `done` stuck at 0 and TIMEOUT_CYCLES = 100: required `res_valid` = 1, `timeout_err` = 1, `res_data` = 0.
  - Pull `rst_n` low after 100 writes: required all outputs 0 immediately.
  - Rerun the all-ones job after reset: required 4096.
